// File: rtl/trainer_pkg.sv
// Shared types and constants for the trainer gate-unit self-test blocks.
package trainer_pkg;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT_STEP,
    DONE
  } state_e;

  // Gate unit select codes. Code 7 is unused by the gate unit.
  localparam logic [2:0] GATE_AND   = 3'd0;
  localparam logic [2:0] GATE_OR    = 3'd1;
  localparam logic [2:0] GATE_NAND  = 3'd2;
  localparam logic [2:0] GATE_NOR   = 3'd3;
  localparam logic [2:0] GATE_XOR   = 3'd4;
  localparam logic [2:0] GATE_XNOR  = 3'd5;
  localparam logic [2:0] GATE_NOT_A = 3'd6;

  // Truth vectors: bit i holds y for {a,b} == i.
  localparam logic [3:0] EXP_AND   = 4'b1000;
  localparam logic [3:0] EXP_OR    = 4'b1110;
  localparam logic [3:0] EXP_NAND  = 4'b0111;
  localparam logic [3:0] EXP_NOR   = 4'b0001;
  localparam logic [3:0] EXP_XOR   = 4'b0110;
  localparam logic [3:0] EXP_XNOR  = 4'b1001;
  localparam logic [3:0] EXP_NOT_A = 4'b0011;

  // Expected vector table indexed by sel; entry 7 is a harmless filler.
  localparam logic [7:0][3:0] EXPECTED = {
    4'b0000,
    EXP_NOT_A,
    EXP_XNOR,
    EXP_XOR,
    EXP_NOR,
    EXP_NAND,
    EXP_OR,
    EXP_AND
  };

endpackage

// File: rtl/trainer_gate_ref.sv
// Combinational reference: gate select code to expected 4-bit truth vector.
module trainer_gate_ref
  import trainer_pkg::*;
(
  input  logic [2:0] sel,
  output logic [3:0] vec
);

  // Table lookup of the golden truth vector for the selected gate.
  always_comb begin
    vec = EXPECTED[sel];
  end

endmodule

// File: rtl/trainer_sweep_ctrl.sv
// Self-test sequencer: sweeps every gate select and input combination of the
// trainer gate unit, waits a programmable settle time, samples y, and reports
// a per-gate mismatch mask plus an overall pass flag.
module trainer_sweep_ctrl
  import trainer_pkg::*;
#(
  parameter int DWELL_W   = 4,
  parameter int NUM_GATES = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic [DWELL_W-1:0]   dwell,
  output logic                 dut_a,
  output logic                 dut_b,
  output logic [2:0]           dut_sel,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask
);

  localparam logic [2:0] LAST_SEL = 3'(NUM_GATES - 1);

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [2:0]           sel_q, sel_d;
  logic [1:0]           ab_q, ab_d;
  logic [3:0]           vec_q, vec_d;
  logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 start_hist_q, start_hist_d;
  logic                 step_hist_q, step_hist_d;
  logic                 start_edge;
  logic                 step_edge;
  logic [3:0]           exp_vec;

  trainer_gate_ref u_gate_ref (
    .sel (sel_q),
    .vec (exp_vec)
  );

  // Rising-edge detection of the level inputs against their history flops.
  always_comb begin
    start_edge   = start & ~start_hist_q;
    step_edge    = step & ~step_hist_q;
    start_hist_d = start;
    step_hist_d  = step;
  end

  // Next-state and datapath updates; abort overrides the whole FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    sel_d       = sel_q;
    ab_d        = ab_q;
    vec_d       = vec_q;
    fail_mask_d = fail_mask_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;

    if (abort) begin
      state_d     = IDLE;
      sel_d       = '0;
      ab_d        = '0;
      fail_mask_d = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            dwell_d     = dwell;
            cnt_d       = dwell;
            sel_d       = '0;
            ab_d        = '0;
            fail_mask_d = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            busy_d      = 1'b1;
            state_d     = SETTLE;
          end
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end

        SAMPLE: begin
          vec_d[ab_q] = dut_y;
          if (ab_q == 2'd3) begin
            // Bit 3 comes straight from dut_y; vec_q holds bits 0..2 already.
            fail_mask_d[sel_q] = ({dut_y, vec_q[2:0]} != exp_vec);
            if (sel_q == LAST_SEL) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (fail_mask_d == '0);
            end else begin
              sel_d = sel_q + 3'd1;
              ab_d  = '0;
            end
          end else begin
            ab_d = ab_q + 2'd1;
          end
          if (state_d != DONE) begin
            cnt_d   = dwell_q;
            state_d = step_mode ? WAIT_STEP : SETTLE;
          end
        end

        WAIT_STEP: begin
          if (step_edge || !step_mode) begin
            state_d = SETTLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; ena low freezes everything including edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dwell_q      <= '0;
      sel_q        <= '0;
      ab_q         <= '0;
      vec_q        <= '0;
      fail_mask_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      start_hist_q <= 1'b0;
      step_hist_q  <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      sel_q        <= sel_d;
      ab_q         <= ab_d;
      vec_q        <= vec_d;
      fail_mask_q  <= fail_mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      start_hist_q <= start_hist_d;
      step_hist_q  <= step_hist_d;
    end
  end

  // Registered outputs.
  always_comb begin
    dut_a     = ab_q[1];
    dut_b     = ab_q[0];
    dut_sel   = sel_q;
    busy      = busy_q;
    done      = done_q;
    pass      = pass_q;
    fail_mask = fail_mask_q;
  end

endmodule
